cordic_engine: RTL and testbench
================================

CORDIC_ENGINE -- requirements
Module: cordic_engine

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 16, data/angle width in bits, legal 8..24.
- ITER, 14, CORDIC iteration count, legal 4..WIDTH-2.
REQ-002 Ports SHALL be, one per line:
- Clk_i  in  1  single clock, all state on rising edge.
- Rst_i  in  1  reset, synchronous and active-high.
- Start_i  in  1  request; accepted only when Busy_o=0.
- Mode_i  in  1  0=rotation (sin/cos), 1=vectoring (magnitude/phase); sampled with Start_i.
- Angle_i  in  WIDTH  signed binary angle, 2^(WIDTH-1) = pi (-32768 = -180 deg at WIDTH=16); used in rotation mode.
- X_i  in  WIDTH  signed input x, Q1.(WIDTH-2); used in vectoring mode.
- Y_i  in  WIDTH  signed input y, Q1.(WIDTH-2); used in vectoring mode.
- Busy_o  out  1  operation in progress.
- Done_o  out  1  one-cycle completion pulse.
- X_o  out  WIDTH  rotation: cos; vectoring: gained magnitude.
- Y_o  out  WIDTH  rotation: sin; vectoring: residual y.
- Z_o  out  WIDTH  rotation: residual angle; vectoring: phase, binary-angle format.

Function
REQ-003 Fixed point SHALL be Q1.(WIDTH-2): 1.0 = 2^(WIDTH-2) (16384 at WIDTH=16).
REQ-004 FSM SHALL have states IDLE, ITER, DONE; IDLE->ITER on Start_i=1, ITER->DONE after ITER iterations, DONE->IDLE after one cycle.
REQ-005 Start_i during ITER SHALL be ignored, with no effect on state or outputs.
REQ-006 Start_i sampled in DONE SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-007 Latency: Start_i accepted at edge k (load) -> iterations at edges k+1..k+ITER -> outputs registered and Done_o=1 after edge k+ITER+1.
REQ-008 Busy_o SHALL be 1 from after edge k until the edge that enters DONE; it SHALL be 0 during the DONE cycle.
REQ-009 Done_o SHALL be high for exactly one cycle per accepted Start_i.
REQ-010 X_o/Y_o/Z_o SHALL change only at the DONE edge and hold their value otherwise.
REQ-011 Internal x/y datapath SHALL be WIDTH+2 bits signed; shifts SHALL be arithmetic (>>> i) with truncation.
REQ-012 z SHALL be WIDTH bits and wrap modulo 2^WIDTH.
REQ-013 atan table entry i SHALL equal round(atan(2^-i) * 2^(WIDTH-1) / pi), computed at elaboration from WIDTH; no hardcoded 16-bit constants.
REQ-014 Rotation load SHALL set x0 = round(0.6072529 * 2^(WIDTH-2)) (9949 at WIDTH=16), y0 = 0, z0 = Angle_i.
REQ-015 Rotation pre-rotation: if |Angle_i| > 90 deg (Angle_i[WIDTH-1] != Angle_i[WIDTH-2]), z0 = Angle_i + pi (mod 2^WIDTH) and x0 is negated.
REQ-016 Rotation step: d = +1 if z >= 0, else -1; x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan(i).
REQ-017 Vectoring load: if X_i >= 0, x0 = X_i, y0 = Y_i, z0 = 0; else x0 = -X_i, y0 = -Y_i, z0 = pi (-2^(WIDTH-1)).
REQ-018 Vectoring step: d = +1 if y < 0, else -1; same x/y/z update equations as REQ-016.
REQ-019 Vectoring magnitude SHALL NOT be gain-compensated (factor approx. 1.64676).
REQ-020 Outputs SHALL saturate from WIDTH+2 bits to the signed WIDTH range.
REQ-021 Accuracy at WIDTH=16, ITER=14 SHALL be within +/-8 LSB of the ideal value on X_o/Y_o/Z_o.

Reset
REQ-022 Rst_i=1 SHALL, at the next edge, set the FSM to IDLE, Busy_o=0, Done_o=0, X_o=Y_o=Z_o=0, and clear the iteration counter and x/y/z.
REQ-023 Reset mid-operation SHALL abort the operation with no Done_o pulse.
REQ-024 Rst_i SHALL dominate a simultaneous Start_i.
REQ-025 The first Start_i after reset release SHALL be accepted normally.

Verification (WIDTH=16, ITER=14, tolerance +/-8 LSB)
REQ-026 Rotation, Angle_i=0 -> X_o approx. 16384, Y_o approx. 0; Done_o exactly 15 cycles after the Start_i edge.
REQ-027 Rotation, Angle_i=5461 (30 deg) -> X_o approx. 14189, Y_o approx. 8192. Angle_i=27307 (150 deg) -> X_o approx. -14189, Y_o approx. 8192.
REQ-028 Rotation, Angle_i=-16384 (-90 deg) -> X_o approx. 0, Y_o approx. -16384.
REQ-029 Vectoring, X_i=8192, Y_i=8192 -> Z_o approx. 8192 (45 deg), X_o approx. 19079. X_i=-8192, Y_i=0 -> Z_o approx. -32768, X_o approx. 13491.
REQ-030 Start_i held high continuously -> Done_o pulses every 16 cycles. A Start_i pulse mid-ITER is ignored. Rst_i at cycle 5 of an operation -> no Done_o pulse and all outputs 0.

Source files
------------

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation mode yields cos/sin of a binary angle,
// vectoring mode yields gained magnitude and phase of an (x, y) vector.
module cordic_engine #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Start_i,
  input  logic             Mode_i,
  input  logic [WIDTH-1:0] Angle_i,
  input  logic [WIDTH-1:0] X_i,
  input  logic [WIDTH-1:0] Y_i,
  output logic             Busy_o,
  output logic             Done_o,
  output logic [WIDTH-1:0] X_o,
  output logic [WIDTH-1:0] Y_o,
  output logic [WIDTH-1:0] Z_o
);

  localparam int CNT_W = $clog2(ITER + 1);
  localparam int DW    = WIDTH + 2;
  localparam real PI   = 3.14159265358979323846;
  localparam int GAIN_INT = $rtoi(0.6072529 * (2.0 ** (WIDTH - 2)) + 0.5);
  localparam logic signed [DW-1:0] X_GAIN  = DW'(GAIN_INT);
  localparam logic signed [DW-1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                state_reg, state_next;
  logic                  load;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  mode_reg;
  logic signed [DW-1:0]  x_reg, y_reg;
  logic [WIDTH-1:0]      z_reg;
  logic [WIDTH-1:0]      x_out_reg, y_out_reg, z_out_reg;

  logic signed [DW-1:0]  x_in_ext, y_in_ext, x_load, y_load, x_shift, y_shift;
  logic [WIDTH-1:0]      z_load;
  logic                  d_pos;

  // Extra entry at index ITER keeps the lookup in range on the output cycle.
  logic [WIDTH-1:0]      atan_tab [ITER+1];

  genvar gi;
  generate
    for (gi = 0; gi <= ITER; gi++) begin : g_atan
      localparam real ANG = $atan(1.0 / (2.0 ** gi)) * (2.0 ** (WIDTH - 1)) / PI;
      localparam int ANG_INT = $rtoi(ANG + 0.5);
      assign atan_tab[gi] = WIDTH'(ANG_INT);
    end
  endgenerate

  function automatic logic [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  always_comb begin
    x_in_ext = DW'($signed(X_i));
    y_in_ext = DW'($signed(Y_i));
    x_load   = X_GAIN;
    y_load   = '0;
    z_load   = Angle_i;
    if (!Mode_i) begin
      // Angles beyond +/-90 deg start from the mirrored point (-K, 0).
      if (Angle_i[WIDTH-1] != Angle_i[WIDTH-2]) begin
        x_load = -X_GAIN;
        z_load = {~Angle_i[WIDTH-1], Angle_i[WIDTH-2:0]};
      end
    end else if (!X_i[WIDTH-1]) begin
      x_load = x_in_ext;
      y_load = y_in_ext;
      z_load = '0;
    end else begin
      x_load = -x_in_ext;
      y_load = -y_in_ext;
      z_load = {1'b1, {(WIDTH-1){1'b0}}};
    end
    d_pos   = mode_reg ? y_reg[DW-1] : ~z_reg[WIDTH-1];
    x_shift = x_reg >>> cnt_reg;
    y_shift = y_reg >>> cnt_reg;
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      S_IDLE: if (Start_i) begin
        state_next = S_ITER;
        load       = 1'b1;
      end
      S_ITER: if (cnt_reg == LAST_STEP) state_next = S_DONE;
      S_DONE: begin
        state_next = S_IDLE;
        if (Start_i) begin
          state_next = S_ITER;
          load       = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      x_out_reg <= '0;
      y_out_reg <= '0;
      z_out_reg <= '0;
    end else if (load) begin
      cnt_reg  <= '0;
      mode_reg <= Mode_i;
      x_reg    <= x_load;
      y_reg    <= y_load;
      z_reg    <= z_load;
    end else if (state_reg == S_ITER) begin
      if (cnt_reg != LAST_STEP) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (d_pos) begin
          x_reg <= x_reg - y_shift;
          y_reg <= y_reg + x_shift;
          z_reg <= z_reg - atan_tab[cnt_reg];
        end else begin
          x_reg <= x_reg + y_shift;
          y_reg <= y_reg - x_shift;
          z_reg <= z_reg + atan_tab[cnt_reg];
        end
      end else begin
        x_out_reg <= sat(x_reg);
        y_out_reg <= sat(y_reg);
        z_out_reg <= z_reg;
      end
    end
  end

  assign Busy_o = (state_reg == S_ITER);
  assign Done_o = (state_reg == S_DONE);
  assign X_o    = x_out_reg;
  assign Y_o    = y_out_reg;
  assign Z_o    = z_out_reg;

endmodule

// File: tb/tb_cordic_engine.sv
// Bench for cordic_engine: directed and random operations compared against
// ideal trigonometry with an LSB tolerance, plus handshake/timing scenarios.
module tb_cordic_engine;
  localparam int WIDTH = 16;
  localparam int ITER  = 14;
  localparam int TOL   = 8;
  localparam int LAT   = ITER + 1;
  localparam real PI   = 3.14159265358979323846;
  localparam real CORDIC_GAIN = 1.6467602581;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic [WIDTH-1:0] angle, x_in, y_in;
  logic busy, done;
  logic [WIDTH-1:0] x_out, y_out, z_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .Clk_i(clk), .Rst_i(rst), .Start_i(start), .Mode_i(mode),
    .Angle_i(angle), .X_i(x_in), .Y_i(y_in),
    .Busy_o(busy), .Done_o(done), .X_o(x_out), .Y_o(y_out), .Z_o(z_out)
  );

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Difference of two binary angles taken modulo a full turn.
  function automatic int wrap_diff(input int a, input int b);
    int d;
    d = (a - b) & 32'hFFFF;
    if (d >= 32768) d = d - 65536;
    return d;
  endfunction

  function automatic int sx(input logic [WIDTH-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic run_op(input logic m, input logic [WIDTH-1:0] a, xv, yv, output int lat);
    @(negedge clk);
    start = 1'b1; mode = m; angle = a; x_in = xv; y_in = yv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; mode = 1'b0; angle = '0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (x_out !== '0) begin errors++; $display("FAIL reset_x: got %0d expected 0", sx(x_out)); end
    checks++; if (y_out !== '0) begin errors++; $display("FAIL reset_y: got %0d expected 0", sx(y_out)); end
    checks++; if (z_out !== '0) begin errors++; $display("FAIL reset_z: got %0d expected 0", sx(z_out)); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    $display("reset: busy=%b done=%b X=%0d Y=%0d Z=%0d", busy, done, sx(x_out), sx(y_out), sx(z_out));
  endtask

  task automatic test_rotation_directed;
    int ang[4] = '{0, 5461, 27307, -16384};
    int ex[4]  = '{16384, 14189, -14189, 0};
    int ey[4]  = '{0, 8192, 8192, -16384};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 16'(ang[i]), '0, '0, lat);
      $display("rot angle=%0d X=%0d Y=%0d Z=%0d lat=%0d", ang[i], sx(x_out), sx(y_out), sx(z_out), lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL rot_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (iabs(sx(x_out) - ex[i]) > TOL) begin errors++; $display("FAIL rot_x: got %0d expected %0d", sx(x_out), ex[i]); end
      checks++; if (iabs(sx(y_out) - ey[i]) > TOL) begin errors++; $display("FAIL rot_y: got %0d expected %0d", sx(y_out), ey[i]); end
    end
  endtask

  task automatic test_vectoring_directed;
    int vx[2] = '{8192, -8192};
    int vy[2] = '{8192, 0};
    int ex[2] = '{19079, 13491};
    int ez[2] = '{8192, -32768};
    int lat;
    for (int i = 0; i < 2; i++) begin
      run_op(1'b1, '0, 16'(vx[i]), 16'(vy[i]), lat);
      $display("vec x=%0d y=%0d X=%0d Y=%0d Z=%0d lat=%0d", vx[i], vy[i], sx(x_out), sx(y_out), sx(z_out), lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL vec_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (iabs(sx(x_out) - ex[i]) > TOL) begin errors++; $display("FAIL vec_mag: got %0d expected %0d", sx(x_out), ex[i]); end
      checks++; if (iabs(wrap_diff(sx(z_out), ez[i])) > TOL) begin errors++; $display("FAIL vec_phase: got %0d expected %0d", sx(z_out), ez[i]); end
    end
  endtask

  task automatic test_random;
    int lat, xv, yv, tries, ex, ey, ez, as;
    logic m;
    logic [WIDTH-1:0] a16;
    real rad;
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      if (!m) begin
        a16 = 16'($urandom_range(0, 65535));
        as  = sx(a16);
        rad = real'(as) * PI / 32768.0;
        ex  = clamp(rnd(16384.0 * $cos(rad)));
        ey  = clamp(rnd(16384.0 * $sin(rad)));
        run_op(1'b0, a16, '0, '0, lat);
        $display("rnd rot angle=%0d X=%0d(%0d) Y=%0d(%0d) Z=%0d", as, sx(x_out), ex, sx(y_out), ey, sx(z_out));
        checks++; if (iabs(sx(x_out) - ex) > TOL) begin errors++; $display("FAIL rnd_rot_x: got %0d expected %0d", sx(x_out), ex); end
        checks++; if (iabs(sx(y_out) - ey) > TOL) begin errors++; $display("FAIL rnd_rot_y: got %0d expected %0d", sx(y_out), ey); end
        checks++; if (iabs(wrap_diff(sx(z_out), 0)) > TOL) begin errors++; $display("FAIL rnd_rot_z: got %0d expected 0", sx(z_out)); end
      end else begin
        tries = 0;
        do begin
          xv = int'($urandom_range(0, 32000)) - 16000;
          yv = int'($urandom_range(0, 32000)) - 16000;
          tries++;
        end while ((xv * xv + yv * yv) < 64000000 && tries < 100);
        ex = clamp(rnd(CORDIC_GAIN * $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv))));
        ez = rnd($atan2(real'(yv), real'(xv)) * 32768.0 / PI);
        run_op(1'b1, '0, 16'(xv), 16'(yv), lat);
        $display("rnd vec x=%0d y=%0d X=%0d(%0d) Z=%0d(%0d)", xv, yv, sx(x_out), ex, sx(z_out), ez);
        checks++; if (iabs(sx(x_out) - ex) > TOL) begin errors++; $display("FAIL rnd_vec_mag: got %0d expected %0d", sx(x_out), ex); end
        checks++; if (iabs(wrap_diff(sx(z_out), ez)) > TOL) begin errors++; $display("FAIL rnd_vec_phase: got %0d expected %0d", sx(z_out), ez); end
      end
      checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_latency: got %0d expected %0d", lat, LAT); end
    end
  endtask

  task automatic test_hold_and_busy;
    int lat, prev_x, prev_y;
    run_op(1'b0, 16'd5461, '0, '0, lat);
    prev_x = sx(x_out);
    prev_y = sx(y_out);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; angle = 16'hC000;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < LAT; c++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_iter: cycle %0d got %b expected 1", c, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_in_iter: cycle %0d got %b expected 0", c, done); end
      checks++; if (sx(x_out) != prev_x || sx(y_out) != prev_y) begin
        errors++; $display("FAIL hold_outputs: cycle %0d got %0d/%0d expected %0d/%0d", c, sx(x_out), sx(y_out), prev_x, prev_y);
      end
      @(posedge clk); #1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_done: got %b expected 0", busy); end
    checks++; if (iabs(sx(y_out) + 16384) > TOL) begin errors++; $display("FAIL hold_new_y: got %0d expected -16384", sx(y_out)); end
    prev_y = sx(y_out);
    @(posedge clk); #1;
    $display("hold: after done busy=%b done=%b Y=%0d", busy, done, sx(y_out));
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done); end
    checks++; if (sx(y_out) != prev_y) begin errors++; $display("FAIL hold_after_done: got %0d expected %0d", sx(y_out), prev_y); end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; angle = '0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (lat == 5) begin
        start = 1'b1; mode = 1'b1; angle = 16'h4000; x_in = 16'hE000; y_in = 16'h1000;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    $display("ignore: X=%0d Y=%0d lat=%0d", sx(x_out), sx(y_out), lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (iabs(sx(x_out) - 16384) > TOL) begin errors++; $display("FAIL ignore_x: got %0d expected 16384", sx(x_out)); end
    checks++; if (iabs(sx(y_out)) > TOL) begin errors++; $display("FAIL ignore_y: got %0d expected 0", sx(y_out)); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_idle: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_back_to_back;
    int prev, pulses, w;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; angle = 16'd5461;
    @(posedge clk); #1;
    prev = -1; pulses = 0;
    for (int e = 1; e <= 66; e++) begin
      @(posedge clk); #1;
      if (done) begin
        $display("b2b: done at edge %0d X=%0d Y=%0d", e, sx(x_out), sx(y_out));
        checks++;
        if (prev < 0) begin
          if (e != LAT) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", e, LAT); end
        end else if (e - prev != LAT + 1) begin
          errors++; $display("FAIL b2b_period: got %0d expected %0d", e - prev, LAT + 1);
        end
        checks++; if (iabs(sx(x_out) - 14189) > TOL) begin errors++; $display("FAIL b2b_x: got %0d expected 14189", sx(x_out)); end
        prev = e;
        pulses++;
      end
    end
    start = 1'b0;
    checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
    w = 0;
    while (!done && w < 40) begin @(posedge clk); #1; w++; end
    checks++; if (!done) begin errors++; $display("FAIL b2b_drain: got done=%b expected 1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    int seen, lat;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; angle = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
    checks++; if (x_out !== '0 || y_out !== '0 || z_out !== '0) begin
      errors++; $display("FAIL abort_outputs: got %0d/%0d/%0d expected 0/0/0", sx(x_out), sx(y_out), sx(z_out));
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (done) seen++; end
    $display("abort: done pulses after reset=%0d X=%0d", seen, sx(x_out));
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", seen); end
    run_op(1'b0, 16'd27307, '0, '0, lat);
    $display("post-reset rot angle=27307 X=%0d Y=%0d lat=%0d", sx(x_out), sx(y_out), lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (iabs(sx(x_out) + 14189) > TOL) begin errors++; $display("FAIL post_reset_x: got %0d expected -14189", sx(x_out)); end
  endtask

  initial begin
    test_reset;
    test_rotation_directed;
    test_vectoring_directed;
    test_random;
    test_hold_and_busy;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
